spi_slave_wide: RTL

- Parametrised SPI slave, next generation of the 8-bit mode-0 slave feeding the lab FSM.
- Supports all four SPI modes, configurable word width and bit order, multi-word frames, and a TX FIFO with underrun and overflow flags.
- Sits between the GPIO SPI pins and application logic (FSM, register bank) in the i_Clk domain.
- SPI pins are oversampled; SCLK must not exceed i_Clk/8.

---
 rtl/spi_slave_wide_pkg.sv | 35 +++
 rtl/spi_tx_fifo.sv | 60 ++++++
 rtl/spi_slave_wide.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_wide_pkg.sv
// Shared definitions for the wide SPI slave: synchroniser depth, frame states,
// SPI mode decode and parameter legality helpers.
package spi_slave_wide_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        FRM_UNARMED,
        FRM_IDLE,
        FRM_ACTIVE
    } frame_state_e;

    function automatic logic mode_cpol(input int mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input int mode);
        return mode[0];
    endfunction

    // Sample edge is the leading edge when CPHA=0; the shift edge is the other one.
    function automatic logic edge_sel(input logic cpha, input logic want_sample,
                                      input logic leading, input logic trailing);
        return (cpha ^ want_sample) ? leading : trailing;
    endfunction

    function automatic bit word_w_legal(input int w);
        return (w >= 4) && (w <= 32);
    endfunction

    function automatic bit depth_legal(input int d);
        return (d >= 2) && (d <= 16) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Show-ahead synchronous TX FIFO; a push into a full FIFO is dropped unless a
// pop happens in the same cycle.
module spi_tx_fifo #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_word,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic              drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_wide.sv
// Oversampled SPI slave with selectable mode, word width and bit order,
// back-to-back multi-word frames and a TX FIFO with underrun/overflow flags.
module spi_slave_wide
    import spi_slave_wide_pkg::*;
#(
    parameter int                SPI_MODE  = 0,
    parameter int                WORD_W    = 8,
    parameter int                MSB_FIRST = 1,
    parameter int                TX_DEPTH  = 4,
    parameter logic [WORD_W-1:0] IDLE_WORD = '1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_SPI_Clk,
    input  logic              i_SPI_CS_n,
    input  logic              i_SPI_MOSI,
    output logic              o_SPI_MISO,
    output logic              o_SPI_MISO_En,
    output logic              o_RX_DV,
    output logic [WORD_W-1:0] o_RX_Word,
    input  logic              i_TX_DV,
    input  logic [WORD_W-1:0] i_TX_Word,
    output logic              o_TX_Ready,
    output logic              o_TX_Underrun,
    output logic              o_TX_Overflow,
    output logic              o_Frame_Err,
    output logic              o_Busy
);
    localparam logic            CPOL     = mode_cpol(SPI_MODE);
    localparam logic            CPHA     = mode_cpha(SPI_MODE);
    localparam int              CW       = $clog2(WORD_W);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WORD_W - 1);
    localparam int              HEAD     = (MSB_FIRST != 0) ? WORD_W - 1 : 0;
    localparam logic [1:0]      SETTLED  = 2'(SYNC_DEPTH + 1);

    if (!word_w_legal(WORD_W)) begin : g_bad_word_w
        $error("spi_slave_wide: WORD_W must be 4..32");
    end
    if (!depth_legal(TX_DEPTH)) begin : g_bad_depth
        $error("spi_slave_wide: TX_DEPTH must be a power of 2 in 2..16");
    end

    logic [SYNC_DEPTH-1:0] sclk_pipe;
    logic [SYNC_DEPTH-1:0] cs_pipe;
    logic [SYNC_DEPTH-1:0] mosi_pipe;
    logic                  sclk_prev;
    logic [1:0]            settle;
    frame_state_e          state;
    logic [CW-1:0]         bit_cnt;
    logic [WORD_W-1:0]     rx_shift;
    logic [WORD_W-1:0]     tx_shift;
    logic [WORD_W-1:0]     rx_next;
    logic [WORD_W-1:0]     tx_adv;
    logic [WORD_W-1:0]     fifo_head;
    logic [WORD_W-1:0]     fetched_word;
    logic                  sclk_s, cs_s, mosi_s;
    logic                  toggled, leading, trailing;
    logic                  sample_edge, shift_edge;
    logic                  frame_start, word_done, fetch;
    logic                  fifo_empty, fifo_full, fifo_drop;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sclk_pipe <= {SYNC_DEPTH{CPOL}};
            cs_pipe   <= '1;
            mosi_pipe <= '0;
            sclk_prev <= CPOL;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_DEPTH-2:0], i_SPI_Clk};
            cs_pipe   <= {cs_pipe[SYNC_DEPTH-2:0], i_SPI_CS_n};
            mosi_pipe <= {mosi_pipe[SYNC_DEPTH-2:0], i_SPI_MOSI};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s       = sclk_pipe[SYNC_DEPTH-1];
    assign cs_s         = cs_pipe[SYNC_DEPTH-1];
    assign mosi_s       = mosi_pipe[SYNC_DEPTH-1];
    assign toggled      = (sclk_s != sclk_prev);
    assign leading      = toggled && (sclk_s != CPOL);
    assign trailing     = toggled && (sclk_s == CPOL);
    assign sample_edge  = (state == FRM_ACTIVE) && !cs_s && edge_sel(CPHA, 1'b1, leading, trailing);
    assign shift_edge   = (state == FRM_ACTIVE) && !cs_s && edge_sel(CPHA, 1'b0, leading, trailing);
    assign frame_start  = (state == FRM_IDLE) && !cs_s;
    assign word_done    = sample_edge && (bit_cnt == LAST_BIT);
    assign fetch        = frame_start || word_done;
    assign fetched_word = fifo_empty ? IDLE_WORD : fifo_head;
    assign o_TX_Ready   = !fifo_full;

    always_comb begin
        rx_next = rx_shift;
        tx_adv  = tx_shift;
        if (MSB_FIRST != 0) begin
            rx_next = {rx_shift[WORD_W-2:0], mosi_s};
            tx_adv  = {tx_shift[WORD_W-2:0], 1'b0};
        end else begin
            rx_next = {mosi_s, rx_shift[WORD_W-1:1]};
            tx_adv  = {1'b0, tx_shift[WORD_W-1:1]};
        end
    end

    spi_tx_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (TX_DEPTH)
    ) u_fifo (
        .clk       (i_Clk),
        .rst       (i_Rst),
        .push      (i_TX_DV),
        .push_word (i_TX_Word),
        .pop       (fetch),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

    // A CS level seen right after reset is not trusted: the block only arms once
    // the flushed synchroniser shows CS high, so a frame caught mid-way is skipped.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            settle        <= '0;
            state         <= FRM_UNARMED;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            o_RX_Word     <= '0;
            o_RX_DV       <= 1'b0;
            o_SPI_MISO    <= 1'b0;
            o_SPI_MISO_En <= 1'b0;
            o_TX_Underrun <= 1'b0;
            o_TX_Overflow <= 1'b0;
            o_Frame_Err   <= 1'b0;
            o_Busy        <= 1'b0;
        end else begin
            o_RX_DV       <= 1'b0;
            o_Frame_Err   <= 1'b0;
            o_TX_Overflow <= fifo_drop;
            o_TX_Underrun <= fetch && fifo_empty;
            if (settle != SETTLED) begin
                settle <= settle + 2'd1;
            end
            case (state)
                FRM_UNARMED: begin
                    if ((settle == SETTLED) && cs_s) begin
                        state <= FRM_IDLE;
                    end
                end
                FRM_IDLE: begin
                    if (frame_start) begin
                        state         <= FRM_ACTIVE;
                        o_Busy        <= 1'b1;
                        o_SPI_MISO_En <= 1'b1;
                        bit_cnt       <= '0;
                        tx_shift      <= fetched_word;
                        if (!CPHA) begin
                            o_SPI_MISO <= fetched_word[HEAD];
                        end
                    end
                end
                FRM_ACTIVE: begin
                    if (cs_s) begin
                        state         <= FRM_IDLE;
                        o_Busy        <= 1'b0;
                        o_SPI_MISO_En <= 1'b0;
                        o_SPI_MISO    <= 1'b0;
                        o_Frame_Err   <= (bit_cnt != '0);
                        bit_cnt       <= '0;
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        if (word_done) begin
                            o_RX_Word <= rx_next;
                            o_RX_DV   <= 1'b1;
                            bit_cnt   <= '0;
                            tx_shift  <= fetched_word;
                            if (!CPHA) begin
                                o_SPI_MISO <= fetched_word[HEAD];
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (shift_edge) begin
                        // bit_cnt==0 here means a fresh word: CPHA=1 shows its first bit, CPHA=0 already did.
                        if (bit_cnt != '0) begin
                            tx_shift   <= tx_adv;
                            o_SPI_MISO <= tx_adv[HEAD];
                        end else if (CPHA) begin
                            o_SPI_MISO <= tx_shift[HEAD];
                        end
                    end
                end
                default: state <= FRM_UNARMED;
            endcase
        end
    end

endmodule
